dcache_mem_bridge: RTL and testbench



---
 rtl/dcache_mem_bridge_if.sv | 31 +++
 rtl/dcache_mem_bridge.sv | 109 ++++++++++
 tb/tb_dcache_mem_bridge.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_bridge_if.sv
// Cache-side line port and single-word memory bus used by dcache_mem_bridge.
// master = cache plus memory environment, slave = the bridge.
interface dcache_mem_bridge_if;
    logic [31:0]  mem_addr;
    logic         mem_r;
    logic         mem_w;
    logic [127:0] mem_data_out;
    logic [127:0] mem_data;
    logic         mem_ready;
    logic         mem_err;
    logic [31:0]  bus_addr;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ack;

    modport master (
        output mem_addr, mem_r, mem_w, mem_data_out,
        output bus_rdata, bus_ack,
        input  mem_data, mem_ready, mem_err,
        input  bus_addr, bus_req, bus_we, bus_wdata
    );

    modport slave (
        input  mem_addr, mem_r, mem_w, mem_data_out,
        input  bus_rdata, bus_ack,
        output mem_data, mem_ready, mem_err,
        output bus_addr, bus_req, bus_we, bus_wdata
    );
endinterface

// File: rtl/dcache_mem_bridge.sv
// Serialises 128-bit cache line fills and write-backs into four
// 32-bit request/acknowledge bus beats, with a per-beat ack timeout.
module dcache_mem_bridge #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned BEATS   = 4
) (
    input logic          clk,
    input logic          rst,
    dcache_mem_bridge_if.slave br
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (BEATS != 4) begin : g_beats_chk
        $error("dcache_mem_bridge: BEATS must be 4");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_chk
        $error("dcache_mem_bridge: TIMEOUT must be 1..65535");
    end

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    logic [1:0]   state;
    logic [1:0]   beat;
    logic [15:0]  timer;
    logic [27:0]  line;
    logic [127:0] buf_q;
    logic [127:0] mem_data_q;
    logic         dir;
    logic         err;
    logic         xfer;
    logic         last;
    logic         to_hit;
    logic [6:0]   woff;
    logic [3:0]   unused_addr;

    assign unused_addr = br.mem_addr[3:0];

    assign xfer   = (state == XFER);
    assign last   = (beat == 2'd3);
    assign to_hit = ((timer + 16'd1) == TO_LIM);
    assign woff   = {beat, 5'd0};

    // buf_q holds the write-back line, or collects read words 0..2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= 2'd0;
            timer      <= 16'd0;
            line       <= 28'd0;
            buf_q      <= 128'd0;
            mem_data_q <= 128'd0;
            dir        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br.mem_w || br.mem_r) begin
                        line  <= br.mem_addr[31:4];
                        dir   <= br.mem_w;
                        beat  <= 2'd0;
                        timer <= 16'd0;
                        err   <= 1'b0;
                        if (br.mem_w)
                            buf_q <= br.mem_data_out;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (br.bus_ack) begin
                        timer <= 16'd0;
                        if (!dir)
                            buf_q[woff +: 32] <= br.bus_rdata;
                        if (last) begin
                            state <= DONE;
                            if (!dir)
                                mem_data_q <= {br.bus_rdata, buf_q[95:0]};
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end else if (to_hit) begin
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from state so reset drops them at once
    assign br.bus_req   = xfer;
    assign br.bus_we    = xfer & dir;
    assign br.bus_addr  = xfer ? {line, beat, 2'b00} : 32'd0;
    assign br.bus_wdata = (xfer & dir) ? buf_q[woff +: 32] : 32'd0;
    assign br.mem_ready = (state == DONE);
    assign br.mem_err   = (state == DONE) & err;
    assign br.mem_data  = mem_data_q;

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Scoreboard bench for dcache_mem_bridge: bus beats and completions
// are queued when requests are driven and checked as they occur.
module tb_dcache_mem_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_mem_bridge_if bif();

    dcache_mem_bridge #(.TIMEOUT(4)) u_dut (
        .clk(clk),
        .rst(rst),
        .br(bif)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;
    int cnt = 0;
    int wait_n = 0;
    bit ack_en = 1'b1;
    logic [127:0] rd_line = 128'd0;
    logic [127:0] model_data = 128'd0;

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder and monitor, evaluated away from the rising edge
    always @(negedge clk) begin
        done_t d;
        if (bif.mem_ready === 1'b1) begin
            ready_cnt++;
            if (done_q.size() == 0) begin
                chk("spurious_ready", bif.mem_ready, 0);
            end else begin
                d = done_q.pop_front();
                chk("mem_data", bif.mem_data, d.data);
                chk("mem_err", bif.mem_err, d.err);
                chk("req_in_done", bif.bus_req, 0);
            end
        end
        if (bif.bus_req !== 1'b1) begin
            bif.bus_ack = 1'b0;
            cnt = 0;
        end else begin
            if (beat_q.size() == 0) begin
                chk("spurious_beat", bif.bus_req, 0);
            end else begin
                chk("bus_addr", bif.bus_addr, beat_q[0].addr);
                chk("bus_we", bif.bus_we, beat_q[0].we);
                if (beat_q[0].we)
                    chk("bus_wdata", bif.bus_wdata, beat_q[0].wdata);
            end
            if (ack_en && cnt >= wait_n) begin
                bif.bus_ack = 1'b1;
                bif.bus_rdata = rd_line[bif.bus_addr[3:2]*32 +: 32];
                cnt = 0;
                if (beat_q.size() > 0)
                    void'(beat_q.pop_front());
            end else begin
                bif.bus_ack = 1'b0;
                cnt++;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after mem_ready
    task automatic xact(string tag, bit r, bit w, logic [31:0] a,
                        logic [127:0] wd, int waits, bit ack, int exp_lat);
        int n;
        logic [31:0] wa;
        n = 0;
        wait_n = waits;
        ack_en = ack;
        bif.mem_r = r;
        bif.mem_w = w;
        bif.mem_addr = a;
        bif.mem_data_out = wd;
        if (w) begin
            for (int i = 0; i < 4; i++) begin
                wa = {a[31:4], 4'(i * 4)};
                beat_q.push_back('{wa, 1'b1, wd[i*32 +: 32]});
            end
            done_q.push_back('{model_data, 1'b0});
        end else if (ack) begin
            for (int i = 0; i < 4; i++) begin
                wa = {a[31:4], 4'(i * 4)};
                beat_q.push_back('{wa, 1'b0, 32'd0});
            end
            done_q.push_back('{rd_line, 1'b0});
            model_data = rd_line;
        end else begin
            wa = {a[31:4], 4'd0};
            beat_q.push_back('{wa, 1'b0, 32'd0});
            done_q.push_back('{model_data, 1'b1});
        end
        do begin
            @(negedge clk);
            n++;
        end while (bif.mem_ready !== 1'b1 && n < 200);
        chk({tag, "_lat"}, n, exp_lat);
        if (r && w) begin
            bif.mem_w = 1'b0;
        end else begin
            bif.mem_r = 1'b0;
            bif.mem_w = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_pulse"}, bif.mem_ready, 0);
        chk({tag, "_req_after"}, bif.bus_req, 0);
        beat_q.delete();
    endtask

    initial begin
        int n;
        int rc0;
        bif.mem_r = 1'b0;
        bif.mem_w = 1'b0;
        bif.mem_addr = 32'd0;
        bif.mem_data_out = 128'd0;
        #1;
        chk("rst_ready", bif.mem_ready, 0);
        chk("rst_err", bif.mem_err, 0);
        chk("rst_req", bif.bus_req, 0);
        chk("rst_we", bif.bus_we, 0);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        chk("rst_data", bif.mem_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rd_line = 128'h11111111_22222222_33333333_44444444;
        xact("rd0", 1'b1, 1'b0, 32'hFFFFFFF0, 128'd0, 0, 1'b1, 5);

        xact("wr0", 1'b0, 1'b1, 32'h5A5A5FF7,
             128'hAAAAAAAA_77777777_66666666_55555555, 0, 1'b1, 5);

        rc0 = ready_cnt;
        rd_line = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        xact("rw_w", 1'b1, 1'b1, 32'h00001238,
             128'h0F0F0F0F_F0F0F0F0_12121212_34343434, 0, 1'b1, 5);
        xact("rw_r", 1'b1, 1'b0, 32'h00001238, 128'd0, 0, 1'b1, 5);
        chk("rw_pulses", ready_cnt - rc0, 2);

        rd_line = 128'h99998888_77776666_55554444_33332222;
        xact("wait3", 1'b1, 1'b0, 32'h80000040, 128'd0, 3, 1'b1, 17);

        xact("tmo", 1'b1, 1'b0, 32'h00C0FFE0, 128'd0, 0, 1'b0, 5);

        rd_line = 128'hA1A1A1A1_B2B2B2B2_C3C3C3C3_D4D4D4D4;
        wait_n = 0;
        ack_en = 1'b1;
        bif.mem_r = 1'b1;
        bif.mem_addr = 32'h00004440;
        for (int i = 0; i < 4; i++)
            beat_q.push_back('{32'h00004440 + 32'(i * 4), 1'b0, 32'd0});
        done_q.push_back('{rd_line, 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bif.bus_req === 1'b1 && bif.bus_addr[3:2] == 2'd2) && n < 20);
        chk("rst_reach_beat2", bif.bus_addr, 32'h00004448);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", bif.bus_req, 0);
        chk("arst_addr", bif.bus_addr, 0);
        chk("arst_data", bif.mem_data, 0);
        bif.mem_r = 1'b0;
        beat_q.delete();
        done_q.delete();
        model_data = 128'd0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_data", bif.mem_data, 0);
        chk("post_rst_req", bif.bus_req, 0);

        rd_line = 128'h0BADF00D_13579BDF_2468ACE0_FEEDFACE;
        xact("rd1", 1'b1, 1'b0, 32'h00004440, 128'd0, 1, 1'b1, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
